// File: rtl/dispatch_unit.sv
// dispatch_unit: issue stage between the instruction queue and the execution
// windows (RS / LSB). Each cycle it pops at most one decoded instruction,
// allocates a ROB entry, renames rd, resolves both source operands to a value
// or a ROB tag, and emits a one-cycle registered dispatch pulse with payload.
// Optional feature macro: DSP_PERF_CNT_EN adds perf_issued / perf_stall counters.
module dispatch_unit #(
  parameter int ROB_W   = 5,
  parameter int NON_DEP = 16,
  parameter int OPE_W   = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rdy,
  input  logic             iq_valid,
  input  logic [31:0]      iq_pc,
  input  logic [31:0]      iq_imm,
  input  logic [OPE_W-1:0] iq_type,
  input  logic [4:0]       iq_rd,
  input  logic [4:0]       iq_rs1,
  input  logic [4:0]       iq_rs2,
  input  logic             iq_use_rs1,
  input  logic             iq_use_rs2,
  input  logic             iq_has_rd,
  input  logic             iq_is_ls,
  output logic             iq_pop,
  output logic [4:0]       rf_rs1,
  output logic [4:0]       rf_rs2,
  input  logic [31:0]      rf_v1,
  input  logic [31:0]      rf_v2,
  input  logic [ROB_W-1:0] rf_q1,
  input  logic [ROB_W-1:0] rf_q2,
  output logic [ROB_W-1:0] rob_qry1,
  output logic [ROB_W-1:0] rob_qry2,
  input  logic             rob_rdy1,
  input  logic             rob_rdy2,
  input  logic [31:0]      rob_val1,
  input  logic [31:0]      rob_val2,
  input  logic             rob_full,
  input  logic [ROB_W-1:0] rob_free_id,
  output logic             rob_alloc,
  output logic             rename_en,
  output logic [4:0]       rename_rd,
  output logic [ROB_W-1:0] rename_id,
  input  logic             full_rs,
  input  logic             full_lsb,
  input  logic             en_cdb_rs,
  input  logic [ROB_W-1:0] cdb_rs_id,
  input  logic [31:0]      cdb_rs_val,
  input  logic             en_cdb_lsb,
  input  logic [ROB_W-1:0] cdb_lsb_id,
  input  logic [31:0]      cdb_lsb_val,
  input  logic             mispredict,
  output logic             enable_to_rs,
  output logic             enable_to_lsb,
  output logic [31:0]      d_pc,
  output logic [31:0]      d_imm,
  output logic [31:0]      d_vj,
  output logic [31:0]      d_vk,
  output logic [ROB_W-1:0] d_qj,
  output logic [ROB_W-1:0] d_qk,
  output logic [ROB_W-1:0] d_rob_id,
  output logic [OPE_W-1:0] d_type,
  output logic [4:0]       d_rd
`ifdef DSP_PERF_CNT_EN
  ,
  output logic [31:0]      perf_issued,
  output logic [31:0]      perf_stall
`endif
);

  localparam logic [ROB_W-1:0] NON_DEP_TAG = ROB_W'(NON_DEP);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t      state;
  logic        issue_ls;
  logic        target_full;
  logic        accept;
  logic [31:0] vj_res;
  logic [31:0] vk_res;
  logic [ROB_W-1:0] qj_res;
  logic [ROB_W-1:0] qk_res;

  // Resolve one operand: unused, clean regfile, RS CDB, LSB CDB, ROB result, else wait on tag.
  function automatic logic [32+ROB_W-1:0] resolve(
    input logic             use_op,
    input logic [ROB_W-1:0] q_in,
    input logic [31:0]      v_in,
    input logic             rob_ready,
    input logic [31:0]      rob_value,
    input logic             cdb_a_en,
    input logic [ROB_W-1:0] cdb_a_id,
    input logic [31:0]      cdb_a_val,
    input logic             cdb_b_en,
    input logic [ROB_W-1:0] cdb_b_id,
    input logic [31:0]      cdb_b_val
  );
    logic [32+ROB_W-1:0] r;
    if (!use_op)                             r = {32'd0, NON_DEP_TAG};
    else if (q_in == NON_DEP_TAG)            r = {v_in, NON_DEP_TAG};
    else if (cdb_a_en && cdb_a_id == q_in)   r = {cdb_a_val, NON_DEP_TAG};
    else if (cdb_b_en && cdb_b_id == q_in)   r = {cdb_b_val, NON_DEP_TAG};
    else if (rob_ready)                      r = {rob_value, NON_DEP_TAG};
    else                                     r = {32'd0, q_in};
    return r;
  endfunction

  assign rf_rs1    = iq_rs1;
  assign rf_rs2    = iq_rs2;
  assign rob_qry1  = rf_q1;
  assign rob_qry2  = rf_q2;
  assign rename_rd = iq_rd;
  assign rename_id = rob_free_id;

  // Accept decision and the combinational handshakes it drives toward IQ, ROB and regfile.
  always_comb begin
    target_full = iq_is_ls ? full_lsb : full_rs;
    accept      = rst_n && rdy && iq_valid && !mispredict && !rob_full && !target_full;
    iq_pop      = accept;
    rob_alloc   = accept;
    rename_en   = accept && iq_has_rd && (iq_rd != 5'd0);
  end

  // Operand resolution for both sources in the accept cycle.
  always_comb begin
    {vj_res, qj_res} = resolve(iq_use_rs1, rf_q1, rf_v1, rob_rdy1, rob_val1,
                               en_cdb_rs, cdb_rs_id, cdb_rs_val,
                               en_cdb_lsb, cdb_lsb_id, cdb_lsb_val);
    {vk_res, qk_res} = resolve(iq_use_rs2, rf_q2, rf_v2, rob_rdy2, rob_val2,
                               en_cdb_rs, cdb_rs_id, cdb_rs_val,
                               en_cdb_lsb, cdb_lsb_id, cdb_lsb_val);
  end

  // The pulse lives one cycle in ISSUE; the stored route picks which window sees it.
  assign enable_to_rs  = (state == ISSUE) && !issue_ls;
  assign enable_to_lsb = (state == ISSUE) && issue_ls;

  // IDLE/ISSUE FSM plus payload capture; a flush forces IDLE, rdy low freezes everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      issue_ls <= 1'b0;
      d_pc     <= '0;
      d_imm    <= '0;
      d_vj     <= '0;
      d_vk     <= '0;
      d_qj     <= NON_DEP_TAG;
      d_qk     <= NON_DEP_TAG;
      d_rob_id <= '0;
      d_type   <= '0;
      d_rd     <= '0;
    end else if (rdy) begin
      if (accept) begin
        state    <= ISSUE;
        issue_ls <= iq_is_ls;
        d_pc     <= iq_pc;
        d_imm    <= iq_imm;
        d_vj     <= vj_res;
        d_vk     <= vk_res;
        d_qj     <= qj_res;
        d_qk     <= qk_res;
        d_rob_id <= rob_free_id;
        d_type   <= iq_type;
        d_rd     <= iq_rd;
      end else begin
        state <= IDLE;
      end
    end
  end

`ifdef DSP_PERF_CNT_EN
  // Issue and stall counters; a flush cycle is not a stall, and both wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else if (rdy) begin
      if (accept)
        perf_issued <= perf_issued + 32'd1;
      if (iq_valid && !accept && !mispredict)
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
